flash_audio_reader: RTL and testbench

Consumes the one-cycle 22 kHz sample strobe produced by the clock-domain edge-detect stage and turns it into a stream of signed 16-bit audio samples read from flash. Each 32-bit flash word holds two samples. The block fetches words over an Avalon-MM style read port, splits each word into its two samples, and walks the address space forward or backward with wrap-around. It sits between the sample-strobe generator and the audio codec / volume-indication logic.

---
 rtl/flash_audio_reader_pkg.sv | 14 +
 rtl/flash_audio_reader_if.sv | 21 ++
 rtl/flash_audio_reader.sv | 148 ++++++++++++++
 tb/tb_flash_audio_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/flash_audio_reader_pkg.sv
// Shared types and constants for the flash-backed audio sample reader.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DV,
        EMIT
    } state_e;

    localparam logic [22:0] END_ADDR_DEFAULT = 23'h7FFFF;
    localparam logic [3:0]  FLASH_BE_ALL     = 4'hF;

endpackage

// File: rtl/flash_audio_reader_if.sv
// Avalon-MM read-only port between the audio reader (master) and flash (slave).
interface flash_audio_reader_if #(
    parameter int ADDR_W = 23
);
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic [3:0]        flash_byteenable;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read, flash_address, flash_byteenable,
        input  flash_waitrequest, flash_readdata, flash_readdatavalid
    );

    modport slave (
        input  flash_read, flash_address, flash_byteenable,
        output flash_waitrequest, flash_readdata, flash_readdatavalid
    );
endinterface

// File: rtl/flash_audio_reader.sv
// Turns the per-sample strobe into signed 16-bit samples fetched two-per-word
// from flash, walking the image forward or backward with wrap-around.
module flash_audio_reader
    import audio_pkg::*;
#(
    parameter int              ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(END_ADDR_DEFAULT)
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        play,
    input  logic        dir,
    input  logic        restart,
    flash_audio_reader_if.master fl,
    output logic [15:0] audio_out,
    output logic        audio_valid,
    output logic        overrun
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic              half_q, half_d;
    logic [31:0]       word_buf_q, word_buf_d;
    logic              word_dir_q, word_dir_d;
    logic              restart_pend_q, restart_pend_d;
    logic              flash_read_q, flash_read_d;
    logic [ADDR_W-1:0] flash_address_q, flash_address_d;
    logic [15:0]       audio_out_q, audio_out_d;
    logic              audio_valid_q, audio_valid_d;
    logic              overrun_q, overrun_d;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic bwd);
        if (bwd)
            return (a == '0) ? END_ADDR : a - ADDR_W'(1);
        else
            return (a == END_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    always_comb begin
        state_d         = state_q;
        word_addr_d     = word_addr_q;
        half_d          = half_q;
        word_buf_d      = word_buf_q;
        word_dir_d      = word_dir_q;
        restart_pend_d  = restart_pend_q;
        flash_read_d    = flash_read_q;
        flash_address_d = flash_address_q;
        audio_out_d     = audio_out_q;
        audio_valid_d   = 1'b0;
        overrun_d       = overrun_q;

        case (state_q)
            IDLE: begin
                if (restart || restart_pend_q) begin
                    word_addr_d    = dir ? END_ADDR : '0;
                    half_d         = 1'b0;
                    restart_pend_d = 1'b0;
                end else if (sample_tick && play) begin
                    if (!half_q) begin
                        state_d         = REQ;
                        flash_read_d    = 1'b1;
                        flash_address_d = word_addr_q;
                        word_dir_d      = dir;
                    end else begin
                        // Second sample comes from the buffer in the order the word was fetched.
                        audio_out_d   = word_dir_q ? word_buf_q[15:0] : word_buf_q[31:16];
                        audio_valid_d = 1'b1;
                        word_addr_d   = next_addr(word_addr_q, word_dir_q);
                        half_d        = 1'b0;
                    end
                end
            end

            REQ: begin
                if (sample_tick) overrun_d = 1'b1;
                if (restart) restart_pend_d = 1'b1;
                if (!fl.flash_waitrequest) begin
                    flash_read_d = 1'b0;
                    state_d      = WAIT_DV;
                end
            end

            WAIT_DV: begin
                if (sample_tick) overrun_d = 1'b1;
                if (restart) restart_pend_d = 1'b1;
                if (fl.flash_readdatavalid) begin
                    // A restart during the fetch drops the word; IDLE applies it.
                    if (restart || restart_pend_q) begin
                        state_d = IDLE;
                    end else begin
                        word_buf_d    = fl.flash_readdata;
                        audio_out_d   = word_dir_q ? fl.flash_readdata[31:16]
                                                   : fl.flash_readdata[15:0];
                        audio_valid_d = 1'b1;
                        half_d        = 1'b1;
                        state_d       = EMIT;
                    end
                end
            end

            EMIT: begin
                if (sample_tick) overrun_d = 1'b1;
                if (restart) restart_pend_d = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            word_addr_q     <= '0;
            half_q          <= 1'b0;
            word_buf_q      <= '0;
            word_dir_q      <= 1'b0;
            restart_pend_q  <= 1'b0;
            flash_read_q    <= 1'b0;
            flash_address_q <= '0;
            audio_out_q     <= '0;
            audio_valid_q   <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_addr_q     <= word_addr_d;
            half_q          <= half_d;
            word_buf_q      <= word_buf_d;
            word_dir_q      <= word_dir_d;
            restart_pend_q  <= restart_pend_d;
            flash_read_q    <= flash_read_d;
            flash_address_q <= flash_address_d;
            audio_out_q     <= audio_out_d;
            audio_valid_q   <= audio_valid_d;
            overrun_q       <= overrun_d;
        end
    end

    assign fl.flash_read       = flash_read_q;
    assign fl.flash_address    = flash_address_q;
    assign fl.flash_byteenable = FLASH_BE_ALL;
    assign audio_out           = audio_out_q;
    assign audio_valid         = audio_valid_q;
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_flash_audio_reader.sv
// Scoreboard bench: stimulus queues expected reads/samples, a flash model and
// an output monitor pop and compare independently.
module tb_flash_audio_reader;
    import audio_pkg::*;

    localparam int          AW = 23;
    localparam logic [22:0] EA = 23'h7FFFF;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        play = 1'b0;
    logic        dir = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        overrun;

    flash_audio_reader_if #(.ADDR_W(AW)) fif();

    flash_audio_reader #(.ADDR_W(AW), .END_ADDR(EA)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .sample_tick (sample_tick),
        .play        (play),
        .dir         (dir),
        .restart     (restart),
        .fl          (fif),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .overrun     (overrun)
    );

    always #10 clk50 = ~clk50;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          stall_left = 0;
    logic [15:0] exp_audio[$];
    logic [22:0] exp_addr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    function automatic logic [31:0] flash_word(input logic [22:0] a);
        case (a)
            23'd0:   return 32'h2222_1111;
            23'd1:   return 32'h4444_3333;
            EA:      return 32'hBBBB_AAAA;
            default: return {a[15:0] ^ 16'hA5A5, a[15:0]};
        endcase
    endfunction

    // Flash slave: waitrequest for stall_left cycles, data one cycle after acceptance.
    initial begin
        logic        acc;
        logic [22:0] acc_addr;
        acc = 1'b0;
        acc_addr = '0;
        fif.flash_waitrequest   = 1'b0;
        fif.flash_readdatavalid = 1'b0;
        fif.flash_readdata      = '0;
        forever begin
            @(negedge clk50);
            fif.flash_readdatavalid = acc;
            if (acc) fif.flash_readdata = flash_word(acc_addr);
            acc = 1'b0;
            if (!reset && fif.flash_read) begin
                if (stall_left > 0) begin
                    fif.flash_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    fif.flash_waitrequest = 1'b0;
                    acc = 1'b1;
                    acc_addr = fif.flash_address;
                    check("byteenable", 32'(fif.flash_byteenable), 32'hF);
                    if (exp_addr.size() == 0)
                        check("read_unexpected", 32'd1, 32'd0);
                    else
                        check("read_addr", 32'(fif.flash_address), 32'(exp_addr.pop_front()));
                end
            end else begin
                fif.flash_waitrequest = 1'b0;
            end
        end
    end

    // Output monitor.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk50);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (audio_valid) begin
                    check("valid_back_to_back", 32'(prev), 32'd0);
                    if (exp_audio.size() == 0)
                        check("audio_unexpected", 32'd1, 32'd0);
                    else
                        check("audio_out", 32'(audio_out), 32'(exp_audio.pop_front()));
                end
                prev = audio_valid;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic tick();
        @(negedge clk50); sample_tick = 1'b1;
        @(negedge clk50); sample_tick = 1'b0;
        cycles(8);
    endtask

    task automatic pulse_restart();
        @(negedge clk50); restart = 1'b1;
        @(negedge clk50); restart = 1'b0;
        cycles(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flash_read"}, 32'(fif.flash_read), 32'd0);
        check({tag, "_flash_address"}, 32'(fif.flash_address), 32'd0);
        check({tag, "_audio_out"}, 32'(audio_out), 32'd0);
        check({tag, "_audio_valid"}, 32'(audio_valid), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        cycles(3);
        check_all_zero("reset");
        reset = 1'b0;
        play  = 1'b1;
        dir   = 1'b0;
        cycles(2);

        // Forward: first tick also checks request and sample latency.
        exp_addr.push_back(23'd0); exp_audio.push_back(16'h1111);
        @(negedge clk50); sample_tick = 1'b1;
        @(negedge clk50); sample_tick = 1'b0;
        check("req_latency", 32'(fif.flash_read), 32'd1);
        @(negedge clk50);
        @(negedge clk50);
        check("audio_latency", 32'(audio_valid), 32'd1);
        cycles(6);
        exp_audio.push_back(16'h2222); tick();
        exp_addr.push_back(23'd1); exp_audio.push_back(16'h3333); tick();
        exp_audio.push_back(16'h4444); tick();

        // Backward from END_ADDR.
        dir = 1'b1;
        pulse_restart();
        exp_addr.push_back(EA); exp_audio.push_back(16'hBBBB); tick();
        exp_audio.push_back(16'hAAAA); tick();
        exp_addr.push_back(EA - 23'd1); exp_audio.push_back(16'h5A5B); tick();

        // Forward wrap from END_ADDR to 0.
        pulse_restart();
        dir = 1'b0;
        exp_addr.push_back(EA); exp_audio.push_back(16'hAAAA); tick();
        exp_audio.push_back(16'hBBBB); tick();
        exp_addr.push_back(23'd0); exp_audio.push_back(16'h1111); tick();
        exp_audio.push_back(16'h2222); tick();

        // Stalled read with restart and a tick inside the stall: data dropped.
        stall_left = 5;
        exp_addr.push_back(23'd1);
        @(negedge clk50); sample_tick = 1'b1;
        @(negedge clk50); sample_tick = 1'b0;
        @(negedge clk50); restart = 1'b1;
        @(negedge clk50); restart = 1'b0; sample_tick = 1'b1;
        @(negedge clk50); sample_tick = 1'b0;
        cycles(12);
        check("overrun_sticky", 32'(overrun), 32'd1);
        exp_addr.push_back(23'd0); exp_audio.push_back(16'h1111); tick();
        exp_audio.push_back(16'h2222); tick();

        // Paused: ticks ignored, output held.
        play = 1'b0;
        tick(); tick(); tick();
        check("pause_hold", 32'(audio_out), 32'h2222);
        play = 1'b1;

        // Reset while waiting for read data.
        exp_addr.push_back(23'd1);
        @(negedge clk50); sample_tick = 1'b1;
        @(negedge clk50); sample_tick = 1'b0;
        @(negedge clk50);
        #2 reset = 1'b1;
        #1 check_all_zero("midread_reset");
        @(negedge clk50); reset = 1'b0;
        cycles(3);
        exp_addr.push_back(23'd0); exp_audio.push_back(16'h1111); tick();

        cycles(5);
        check("audio_queue_drained", 32'(exp_audio.size()), 32'd0);
        check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
